// File: rtl/wb_commit_buf_if.sv
// Bundle between the back end and the write-back commit buffer:
// result inputs, retire hold, register-file write ports and status.
interface wb_commit_buf_if #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                   in0_valid;
   logic [ADDR_W-1:0]      in0_waddr;
   logic [DATA_W-1:0]      in0_wdata;
   logic                   in1_valid;
   logic [ADDR_W-1:0]      in1_waddr;
   logic [DATA_W-1:0]      in1_wdata;
   logic                   in_ready;
   logic                   hold;
   logic                   we1;
   logic [ADDR_W-1:0]      waddr1;
   logic [DATA_W-1:0]      wdata1;
   logic                   we2;
   logic [ADDR_W-1:0]      waddr2;
   logic [DATA_W-1:0]      wdata2;
   logic [(1<<ADDR_W)-1:0] pending;
   logic [CNT_W-1:0]       count;

   modport master (
      output in0_valid, in0_waddr, in0_wdata,
      output in1_valid, in1_waddr, in1_wdata,
      output hold,
      input  in_ready,
      input  we1, waddr1, wdata1,
      input  we2, waddr2, wdata2,
      input  pending, count
   );

   modport slave (
      input  in0_valid, in0_waddr, in0_wdata,
      input  in1_valid, in1_waddr, in1_wdata,
      input  hold,
      output in_ready,
      output we1, waddr1, wdata1,
      output we2, waddr2, wdata2,
      output pending, count
   );
endinterface

// File: rtl/wb_commit_buf.sv
// In-order write-back commit buffer: accepts up to two results per cycle and
// retires up to two per cycle onto the register-file ports, younger on port 1.
module wb_commit_buf #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic          clk,
   input  logic          rst,
   wb_commit_buf_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int NREG  = 1 << ADDR_W;

   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [ADDR_W-1:0] addr_d [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [PTR_W-1:0]  rptr_q, rptr_d, wptr_q, wptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              ready;
   logic              acc0, acc1;
   logic [1:0]        n_ret;
   logic [PTR_W-1:0]  rptr_nx, wptr_nx;
   logic [NREG-1:0]   pending_v;

   always_comb begin
      ready   = (count_q <= CNT_W'(DEPTH - 2));
      acc0    = bus.in0_valid && ready && (bus.in0_waddr != '0);
      acc1    = bus.in1_valid && ready && (bus.in1_waddr != '0);
      rptr_nx = rptr_q + PTR_W'(1);
      wptr_nx = wptr_q + PTR_W'(1);
      if (bus.hold || count_q == '0) begin
         n_ret = 2'd0;
      end else if (count_q == CNT_W'(1)) begin
         n_ret = 2'd1;
      end else begin
         n_ret = 2'd2;
      end
   end

   // A lone retiring entry goes to port 1; in a pair the younger takes port 1
   // so the register file's port-1 priority keeps the newest value.
   always_comb begin
      bus.we1    = 1'b0;
      bus.waddr1 = '0;
      bus.wdata1 = '0;
      bus.we2    = 1'b0;
      bus.waddr2 = '0;
      bus.wdata2 = '0;
      if (n_ret == 2'd1) begin
         bus.we1    = 1'b1;
         bus.waddr1 = addr_q[rptr_q];
         bus.wdata1 = data_q[rptr_q];
      end else if (n_ret == 2'd2) begin
         bus.we2    = 1'b1;
         bus.waddr2 = addr_q[rptr_q];
         bus.wdata2 = data_q[rptr_q];
         bus.we1    = 1'b1;
         bus.waddr1 = addr_q[rptr_nx];
         bus.wdata1 = data_q[rptr_nx];
      end
   end

   always_comb begin
      pending_v = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i]) begin
            pending_v[addr_q[i]] = 1'b1;
         end
      end
      pending_v[0] = 1'b0;
   end

   assign bus.pending  = pending_v;
   assign bus.count    = count_q;
   assign bus.in_ready = ready;

   // Retired and newly written slots never overlap because accepts require
   // at least two free entries before this cycle's retirement.
   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      if (n_ret == 2'd1) begin
         valid_d[rptr_q] = 1'b0;
         rptr_d          = rptr_nx;
      end else if (n_ret == 2'd2) begin
         valid_d[rptr_q]  = 1'b0;
         valid_d[rptr_nx] = 1'b0;
         rptr_d           = rptr_q + PTR_W'(2);
      end
      if (acc0 && acc1) begin
         valid_d[wptr_q]  = 1'b1;
         addr_d[wptr_q]   = bus.in0_waddr;
         data_d[wptr_q]   = bus.in0_wdata;
         valid_d[wptr_nx] = 1'b1;
         addr_d[wptr_nx]  = bus.in1_waddr;
         data_d[wptr_nx]  = bus.in1_wdata;
         wptr_d           = wptr_q + PTR_W'(2);
      end else if (acc0) begin
         valid_d[wptr_q] = 1'b1;
         addr_d[wptr_q]  = bus.in0_waddr;
         data_d[wptr_q]  = bus.in0_wdata;
         wptr_d          = wptr_nx;
      end else if (acc1) begin
         valid_d[wptr_q] = 1'b1;
         addr_d[wptr_q]  = bus.in1_waddr;
         data_d[wptr_q]  = bus.in1_wdata;
         wptr_d          = wptr_nx;
      end
      count_d = count_q + CNT_W'(acc0) + CNT_W'(acc1) - CNT_W'(n_ret);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end
endmodule
